// File: rtl/uart_boot_loader.sv
// UART boot loader: receives an image over rx and writes it to memory, holding the core in reset.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte before release.
module uart_boot_loader #(
    parameter int CLK_FREQ    = 12000000,
    parameter int BIT_RATE    = 115200,
    parameter int MEMORY_SIZE = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        memory_write,
    output logic [31:0] address,
    output logic [31:0] write_data,
    output logic [2:0]  option,
    output logic        core_reset,
    output logic        done,
    output logic        error
);
    localparam int CPB = CLK_FREQ / BIT_RATE;
    localparam logic [15:0] CPB_M1 = 16'(CPB - 1);
    localparam logic [15:0] HALF_M1 = 16'(CPB / 2 - 1);
    localparam logic [8:0] MAX_WORDS = 9'(MEMORY_SIZE / 4);

    typedef enum logic [1:0] {R_IDLE, R_START, R_BITS, R_STOP} rx_state_t;
    typedef enum logic [2:0] {
        SYNC, LEN, DATA, WRITE,
`ifdef BOOT_CHECKSUM_EN
        CHECK,
`endif
        DONE, ERROR
    } state_t;

`ifdef BOOT_CHECKSUM_EN
    localparam state_t AFTER_LOAD = CHECK;
`else
    localparam state_t AFTER_LOAD = DONE;
`endif

    logic        rx_m, rx_s, rx_q;
    rx_state_t   rx_st;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg, rx_byte;
    logic        byte_valid, frame_err;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [7:0]  word_idx, n_words;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign option = 3'b010;

    // rx_q delays rx_s once more so a falling edge can be detected
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_q <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_st      <= R_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (rx_st)
                R_IDLE: if (rx_q && !rx_s) begin
                    rx_st <= R_START;
                    cnt   <= '0;
                end
                R_START: if (cnt == HALF_M1) begin
                    rx_st   <= rx_s ? R_IDLE : R_BITS;
                    cnt     <= '0;
                    bit_idx <= '0;
                end else begin
                    cnt <= cnt + 16'd1;
                end
                R_BITS: if (cnt == CPB_M1) begin
                    shreg   <= {rx_s, shreg[7:1]};
                    cnt     <= '0;
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        rx_st <= R_STOP;
                end else begin
                    cnt <= cnt + 16'd1;
                end
                R_STOP: if (cnt == CPB_M1) begin
                    rx_st <= R_IDLE;
                    cnt   <= '0;
                    if (rx_s) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= shreg;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 16'd1;
                end
                default: rx_st <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SYNC;
            memory_write <= 1'b0;
            address      <= '0;
            write_data   <= '0;
            core_reset   <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            byte_cnt     <= '0;
            word_idx     <= '0;
            n_words      <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            memory_write <= 1'b0;
            if (frame_err && state != DONE && state != ERROR) begin
                state <= ERROR;
            end else begin
                unique case (state)
                    SYNC: if (byte_valid && rx_byte == 8'hA5)
                        state <= LEN;
                    LEN: if (byte_valid) begin
                        n_words  <= rx_byte;
                        byte_cnt <= '0;
                        word_idx <= '0;
                        if ({1'b0, rx_byte} > MAX_WORDS)
                            state <= ERROR;
                        else if (rx_byte == 8'd0)
                            state <= AFTER_LOAD;
                        else
                            state <= DATA;
                    end
                    DATA: if (byte_valid) begin
                        // first byte clears the word so no stale bytes survive
                        if (byte_cnt == 2'd0)
                            write_data <= {24'd0, rx_byte};
                        else
                            write_data[{byte_cnt, 3'b000} +: 8] <= rx_byte;
`ifdef BOOT_CHECKSUM_EN
                        csum <= csum ^ rx_byte;
`endif
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state        <= WRITE;
                            memory_write <= 1'b1;
                            address      <= {22'd0, word_idx, 2'b00};
                        end
                    end
                    WRITE: begin
                        word_idx <= word_idx + 8'd1;
                        if (word_idx + 8'd1 == n_words)
                            state <= AFTER_LOAD;
                        else
                            state <= DATA;
                    end
`ifdef BOOT_CHECKSUM_EN
                    CHECK: if (byte_valid)
                        state <= (rx_byte == csum) ? DONE : ERROR;
`endif
                    DONE: begin
                        core_reset <= 1'b0;
                        done       <= 1'b1;
                    end
                    ERROR: begin
                        core_reset <= 1'b1;
                        error      <= 1'b1;
                    end
                    default: state <= ERROR;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: serial images vs. a queue-based write model.
// Build with BOOT_CHECKSUM_EN defined to exercise the checksum byte.
module tb_uart_boot_loader;
    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        memory_write;
    logic [31:0] address, write_data;
    logic [2:0]  option;
    logic        core_reset, done, error;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  img[128];
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];

    uart_boot_loader #(
        .CLK_FREQ(1000000),
        .BIT_RATE(100000),
        .MEMORY_SIZE(128)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .memory_write(memory_write),
        .address(address),
        .write_data(write_data),
        .option(option),
        .core_reset(core_reset),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (memory_write)
            obs_q.push_back({address, write_data});

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_mw", 64'(memory_write), 64'd0);
        chk("rst_addr", 64'(address), 64'd0);
        chk("rst_wdata", 64'(write_data), 64'd0);
        chk("rst_option", 64'(option), 64'd2);
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        #1 reset = 1'b0;
        obs_q.delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat ($urandom_range(2, 12)) @(posedge clk);
        #1;
    endtask

    task automatic wait_end(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || error)
                break;
        end
        chk("finish_in_time", 64'(done | error), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_end(input logic ok);
        chk("done", 64'(done), 64'(ok));
        chk("error", 64'(error), 64'(!ok));
        chk("core_reset", 64'(core_reset), 64'(!ok));
    endtask

    task automatic check_writes();
        int n;
        chk("n_writes", 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk("write", obs_q[i], exp_q[i]);
    endtask

    task automatic set_word(input int w, input logic [31:0] v);
        for (int k = 0; k < 4; k++)
            img[4*w+k] = v[8*k +: 8];
    endtask

    task automatic run_image(input int n, input logic bad_sum);
        logic [7:0] x;
        x = 8'd0;
        exp_q.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'(n), 1'b1);
        for (int i = 0; i < 4*n; i++) begin
            send_byte(img[i], 1'b1);
            x ^= img[i];
        end
        for (int w = 0; w < n; w++)
            exp_q.push_back({32'(4*w), img[4*w+3], img[4*w+2],
                             img[4*w+1], img[4*w]});
`ifdef BOOT_CHECKSUM_EN
        send_byte(x ^ {7'd0, bad_sum}, 1'b1);
`endif
        wait_end(400);
        expect_end(!bad_sum);
        check_writes();
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        do_reset();

        set_word(0, 32'h00100513);
        set_word(1, 32'hDEADBEEF);
        run_image(2, 1'b0);
        if (obs_q.size() == 2) begin
            chk("t1_w0", obs_q[0], 64'h00000000_00100513);
            chk("t1_w1", obs_q[1], 64'h00000004_DEADBEEF);
        end else begin
            chk("t1_count", 64'(obs_q.size()), 64'd2);
        end

        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h5A, 1'b1);
        set_word(0, 32'h04030201);
        run_image(1, 1'b0);

        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h21, 1'b1);
        wait_end(400);
        expect_end(1'b0);
        chk("oversize_writes", 64'(obs_q.size()), 64'd0);

        do_reset();
        for (int i = 0; i < 128; i++)
            img[i] = 8'($urandom);
        run_image(32, 1'b0);
        if (obs_q.size() > 0)
            chk("last_addr", 64'(obs_q[obs_q.size()-1][63:32]), 64'h7C);

        do_reset();
        run_image(0, 1'b0);

        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b0);
        wait_end(400);
        expect_end(1'b0);
        chk("frame_writes", 64'(obs_q.size()), 64'd0);

        do_reset();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_done", 64'(done), 64'd0);
        chk("glitch_error", 64'(error), 64'd0);
        chk("glitch_writes", 64'(obs_q.size()), 64'd0);
        #1;
        set_word(0, 32'hCAFEF00D);
        run_image(1, 1'b0);

        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        #1 reset = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        #1 reset = 1'b0;
        obs_q.delete();
        repeat (3) @(posedge clk);
        #1;
        set_word(0, 32'h44332211);
        run_image(1, 1'b0);

`ifdef BOOT_CHECKSUM_EN
        do_reset();
        set_word(0, 32'h00100513);
        set_word(1, 32'hDEADBEEF);
        run_image(2, 1'b1);
`endif

        for (int r = 0; r < 6; r++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 10);
            for (int i = 0; i < 4*n; i++)
                img[i] = 8'($urandom);
            run_image(n, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
